// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the 10-slot TDM receive demultiplexer.
package tdm_pkg;

  typedef enum logic [0:0] {
    StHunt,
    StRecv
  } tdm_state_e;

  localparam int unsigned NSlots = 10;
  localparam int unsigned SlotW  = $clog2(NSlots);

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-N slot counter; clear has priority over load1, which has priority over inc.
module tdm_slot_counter #(
  parameter int unsigned N  = 10,
  parameter int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clear,
  output logic [SW-1:0] slot
);

  logic [SW-1:0] slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (inc) begin
      slot_d = (slot_q == SW'(N - 1)) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux_10.sv
// Receive-side TDM demux: hunts for sof, reassembles N-slot frames into a parallel word.
module tdm_demux_10
  import tdm_pkg::*;
#(
  parameter int unsigned N  = NSlots,
  parameter int unsigned SW = SlotW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          vld,
  input  logic          sof,
  output logic [SW-1:0] s,
  output logic [N-1:0]  o,
  output logic          frame_done,
  output logic          sync_err,
  output logic          locked
);

  tdm_state_e    state_d, state_q;
  logic [N-1:0]  shadow_d, shadow_q;
  logic [N-1:0]  o_d, o_q;
  logic          frame_done_d, frame_done_q;
  logic          sync_err_d, sync_err_q;
  logic          slot_inc, slot_load1, slot_clear;
  logic [SW-1:0] slot;

  tdm_slot_counter #(
    .N  (N),
    .SW (SW)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (slot_inc),
    .load1 (slot_load1),
    .clear (slot_clear),
    .slot  (slot)
  );

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    o_d          = o_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    slot_inc     = 1'b0;
    slot_load1   = 1'b0;
    slot_clear   = 1'b0;
    if (vld) begin
      unique case (state_q)
        StHunt: begin
          if (sof) begin
            shadow_d[0] = din;
            slot_load1  = 1'b1;
            state_d     = StRecv;
          end
        end
        StRecv: begin
          if (sof && (slot != '0)) begin
            // Misplaced sof restarts the frame at slot 0; partial frame is dropped.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            slot_load1  = 1'b1;
          end else begin
            shadow_d[slot] = din;
            if (slot == SW'(N - 1)) begin
              o_d          = {din, shadow_q[N-2:0]};
              frame_done_d = 1'b1;
              slot_clear   = 1'b1;
            end else begin
              slot_inc = 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      shadow_q     <= '0;
      o_q          <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      o_q          <= o_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign s          = slot;
  assign o          = o_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == StRecv);

endmodule

// File: tb/tb_tdm_demux_10.sv
// Self-checking bench for tdm_demux_10: vector table, directed corner cases, random vs model.
module tb_tdm_demux_10;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       vld;
  logic       sof;
  logic [3:0] s;
  logic [9:0] o;
  logic       frame_done;
  logic       sync_err;
  logic       locked;

  int checks;
  int errors;

  tdm_demux_10 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .vld        (vld),
    .sof        (sof),
    .s          (s),
    .o          (o),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: collect bits by slot index, publish on the last slot.
  bit         m_locked;
  int         m_slot;
  bit         m_bits[10];
  logic [9:0] m_o;
  bit         m_fd;
  bit         m_se;

  task automatic model_reset();
    m_locked = 0;
    m_slot   = 0;
    m_o      = '0;
    m_fd     = 0;
    m_se     = 0;
    for (int k = 0; k < 10; k++) m_bits[k] = 0;
  endtask

  task automatic model_step(input bit v, input bit sf, input bit d);
    m_fd = 0;
    m_se = 0;
    if (v) begin
      if (!m_locked) begin
        if (sf) begin
          m_locked  = 1;
          m_bits[0] = d;
          m_slot    = 1;
        end
      end else if (sf && m_slot != 0) begin
        m_se      = 1;
        m_bits[0] = d;
        m_slot    = 1;
      end else begin
        m_bits[m_slot] = d;
        if (m_slot == 9) begin
          for (int k = 0; k < 10; k++) m_o[k] = m_bits[k];
          m_fd   = 1;
          m_slot = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic beat(input bit v, input bit sf, input bit d);
    @(negedge clk);
    vld = v;
    sof = sf;
    din = d;
    @(posedge clk);
    #1;
    model_step(v, sf, d);
    chk("model", {15'd0, s, o, frame_done, sync_err, locked},
        {15'd0, 4'(m_slot), m_o, m_fd, m_se, m_locked});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld   = 1'b0;
    sof   = 1'b0;
    din   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {15'd0, s, o, frame_done, sync_err, locked}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         vld;
    bit         sof;
    bit         din;
    logic [3:0] s;
    bit         fd;
    bit         se;
    bit         lk;
    logic [9:0] o;
  } vec_t;

  vec_t       vecs[21];
  bit         f1[10];
  bit         f2[10];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    vld    = 1'b0;
    sof    = 1'b0;
    din    = 1'b0;
    f1 = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    f2 = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    // Back-to-back frames 0x2AB (with sof) then 0x154 (without sof), then one idle cycle.
    for (int i = 0; i < 20; i++) begin
      vecs[i].vld = 1;
      vecs[i].sof = (i == 0);
      vecs[i].din = (i < 10) ? f1[i] : f2[i-10];
      vecs[i].s   = 4'((i + 1) % 10);
      vecs[i].fd  = (i == 9) || (i == 19);
      vecs[i].se  = 0;
      vecs[i].lk  = 1;
      vecs[i].o   = (i < 9) ? 10'h000 : (i < 19) ? 10'h2AB : 10'h154;
    end
    vecs[20] = '{vld: 0, sof: 0, din: 0, s: 4'd0, fd: 0, se: 0, lk: 1, o: 10'h154};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      beat(vecs[i].vld, vecs[i].sof, vecs[i].din);
      chk($sformatf("vec%0d", i), {15'd0, s, o, frame_done, sync_err, locked},
          {15'd0, vecs[i].s, vecs[i].o, vecs[i].fd, vecs[i].se, vecs[i].lk});
    end

    // Beats without sof while hunting are discarded.
    do_reset();
    for (int i = 0; i < 7; i++) beat(1, 0, i[0]);
    chk("hunt_discard", {15'd0, s, o, frame_done, sync_err, locked}, 32'd0);

    // Gap of three idle cycles between slots 3 and 4.
    do_reset();
    for (int i = 0; i < 4; i++) beat(1, i == 0, f1[i]);
    for (int g = 0; g < 3; g++) begin
      beat(0, 0, 1);
      chk("gap_hold_s", 32'(s), 32'd4);
    end
    for (int i = 4; i < 10; i++) beat(1, 0, f1[i]);
    chk("gap_frame", {21'd0, frame_done, o}, {21'd0, 1'b1, 10'h2AB});

    // Misplaced sof at slot 5 restarts the frame.
    do_reset();
    for (int i = 0; i < 10; i++) beat(1, i == 0, f1[i]);
    for (int i = 0; i < 5; i++) beat(1, 0, 1);
    chk("pre_sync_s", 32'(s), 32'd5);
    beat(1, 1, 0);
    chk("sync_err", {15'd0, s, o, frame_done, sync_err, locked},
        {15'd0, 4'd1, 10'h2AB, 1'b0, 1'b1, 1'b1});
    beat(1, 0, 1);
    chk("sync_err_pulse", 32'(sync_err), 32'd0);
    for (int i = 0; i < 8; i++) beat(1, 0, 1);
    chk("resync_frame", {21'd0, frame_done, o}, {21'd0, 1'b1, 10'h3FE});

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    do_reset();
    for (int i = 0; i < 10; i++) beat(1, i == 0, f1[i]);
    for (int i = 0; i < 6; i++) beat(1, 0, 1);
    chk("pre_rst_s", 32'(s), 32'd6);
    @(negedge clk);
    vld   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {15'd0, s, o, frame_done, sync_err, locked}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 0, 1);
    chk("post_rst_unlocked", {30'd0, locked, frame_done}, 32'd0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_10.md
# tdm_demux_10

Receive-side time-division demultiplexer: the far end of the 10-to-1 select-mux link. A single serial bit line carries one bit per slot, with a start-of-frame marker on slot 0. The block reassembles each 10-slot frame into a 10-bit parallel word. It presents the current slot index so the upstream mux select can run in lockstep, and it flags framing errors.

## Interface
- N, 10, slots per frame (2..16)
- SW, 4, slot-index width, equal to clog2(N)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din  in  1  serial data bit (mux output y)
- vld  in  1  din is valid this cycle (one beat)
- sof  in  1  start of frame; meaningful only when vld=1; marks a slot-0 beat
- s  out  SW  slot index the next valid beat is written to; drives upstream mux select
- o  out  N  last complete frame; o[k] is the bit received in slot k
- frame_done  out  1  one-cycle pulse when o is updated
- sync_err  out  1  one-cycle pulse on a misplaced sof
- locked  out  1  high while in RECV

## Operation
- Reset is asynchronous on rst_n=0. While reset is asserted:
  - state is HUNT, slot counter is 0, shadow register is 0
  - o is 0, frame_done is 0, sync_err is 0, locked is 0
- State HUNT:
  - Beats with vld=1 and sof=0 are discarded, and s stays 0.
  - A beat with vld=1 and sof=1 writes shadow[0]=din, sets slot to 1, and moves to RECV.
- State RECV, beat with vld=1 and sof=0:
  - Writes shadow[slot]=din.
  - If slot==N-1: loads o={din, shadow[N-2:0]}, pulses frame_done, sets slot to 0, stays in RECV.
  - Otherwise: slot increments by 1.
  - After lock, sof is optional on slot 0.
- State RECV, beat with vld=1 and sof=1:
  - If slot==0: treated as a normal slot-0 write, and slot goes to 1.
  - If slot!=0: pulses sync_err and discards the partial frame. The beat is then written as slot 0 (shadow[0]=din) and slot goes to 1. o is unchanged and there is no frame_done.
- vld=0: no state change. The slot counter and shadow register hold, so gaps of any length are legal.
- The slot counter is mod-N, wrapping from N-1 to 0. Values N..2^SW-1 are never reached.
- s is always equal to the slot counter and is 0 in HUNT.
- locked is equal to (state==RECV).
- o holds its value between completions. The shadow register is not cleared on completion; every bit is rewritten before the next frame completes.

## Timing
- All outputs are registered.
- A beat sampled on edge k produces its effects (s, o, frame_done, sync_err, locked) after edge k.
- frame_done and sync_err are high for exactly one cycle. They cannot be high at the same time.
- frame_done latency is 1 cycle from the slot N-1 beat. The minimum frame period is N cycles with vld held at 1.
- With vld held at 1, s steps 0,1,…,9,0 on consecutive cycles.
- Deasserting rst_n mid-frame clears all state immediately. After rst_n is released, a new sof is needed to lock again.

## Structure
- Package tdm_pkg contains:
  - the state type with values HUNT and RECV
  - the default N and SW, with SW derived as clog2(N)
- One sub-module, tdm_slot_counter: a mod-N counter with inputs inc (advance), load1 (set slot to 1 on sof) and clear (to 0), and output the slot value.
- The top level contains the FSM, the shadow register, the o register and the pulse logic.

## Test plan
- Reset, then 10 contiguous beats with sof on the first. din is slot0..9 = 1,1,0,1,0,1,0,1,0,1 → s steps 0..9 then 0; after beat 10, o=10'b1010101011 with a single-cycle frame_done; locked=1 from beat 1.
- After reset, 7 beats with sof=0 → s=0, locked=0, o=0, no frame_done.
- Same frame as the first test with vld=0 for 3 cycles between beats 4 and 5 → s holds at 4 during the gap; same o value one beat later than the contiguous case.
- While locked, at s=5, a beat with sof=1 and din=0 → one-cycle sync_err, o unchanged, s=1; 9 further beats give frame_done with o[0]=0.
- Assert rst_n=0 at s=6 → o=0, s=0, locked=0 immediately; a sof-less beat after release is ignored.
- Back-to-back frames: 10'b1010101011 with sof, then 10'b0101010100 without sof → frame_done on cycles 10 and 20; o ends at 10'b0101010100; no sync_err.
